// File: rtl/nor4_selftest_seq_if.sv
// Signal bundle between the quad-NOR self-test sequencer and the gate package under test.
// master: sequencer side; slave: gate package / test-rig side.
interface nor4_selftest_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] fail_gate;
    logic [1:0] fail_vec;
    logic [3:0] err_count;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, fail_gate, fail_vec, err_count
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, fail_gate, fail_vec, err_count
    );
endinterface

// File: rtl/nor4_selftest_seq.sv
// Self-test sequencer for a quad 2-input NOR package: walks every gate through all four
// input vectors and reports pass/fail. Optional macro NOR_SELFTEST_STOP_ON_FAIL_EN ends a run at the first bad check.
module nor4_selftest_seq #(
    parameter int unsigned SETTLE = 2
) (
    input  logic            clock,
    input  logic            reset,
    nor4_selftest_if.master bus
);

    localparam int unsigned CNT_W   = $clog2(SETTLE + 1);
    localparam int unsigned ERR_MAX = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         g_q, g_nxt;
    logic [1:0]         v_q, v_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [3:0]         a_q, a_nxt;
    logic [3:0]         b_q, b_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic               pass_q, pass_nxt;
    logic [1:0]         fg_q, fg_nxt;
    logic [1:0]         fv_q, fv_nxt;
    logic [3:0]         err_q, err_nxt;

    logic [3:0]         mism_c;
    logic               any_mism_c;
    logic               last_step_c;
    logic               a_bit_c;
    logic               b_bit_c;

    function automatic logic [1:0] lowest_bit(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Vector table: v0=(0,0) v1=(1,0) v2=(1,1) v3=(0,1)
    assign a_bit_c     = (v_q == 2'd1) || (v_q == 2'd2);
    assign b_bit_c     = (v_q == 2'd2) || (v_q == 2'd3);
    assign mism_c      = bus.y ^ ~(a_q | b_q);
    assign any_mism_c  = |mism_c;
    assign last_step_c = (g_q == 2'd3) && (v_q == 2'd3);

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            g_q    <= 2'd0;
            v_q    <= 2'd0;
            cnt_q  <= '0;
            a_q    <= 4'd0;
            b_q    <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fg_q   <= 2'd0;
            fv_q   <= 2'd0;
            err_q  <= 4'd0;
        end else begin
            state  <= state_nxt;
            g_q    <= g_nxt;
            v_q    <= v_nxt;
            cnt_q  <= cnt_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            pass_q <= pass_nxt;
            fg_q   <= fg_nxt;
            fv_q   <= fv_nxt;
            err_q  <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = S_DRIVE;
            S_DRIVE:        state_nxt = S_WAIT;
            S_WAIT:         if (cnt_q == '0) state_nxt = S_CHECK;
            S_CHECK: begin
`ifdef NOR_SELFTEST_STOP_ON_FAIL_EN
                if (any_mism_c || last_step_c) state_nxt = S_DONE;
                else                           state_nxt = S_DRIVE;
`else
                if (last_step_c) state_nxt = S_DONE;
                else             state_nxt = S_DRIVE;
`endif
            end
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        g_nxt   = g_q;
        v_nxt   = v_q;
        cnt_nxt = cnt_q;
        a_nxt   = a_q;
        b_nxt   = b_q;
        fg_nxt  = fg_q;
        fv_nxt  = fv_q;
        err_nxt = err_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    g_nxt   = 2'd0;
                    v_nxt   = 2'd0;
                    fg_nxt  = 2'd0;
                    fv_nxt  = 2'd0;
                    err_nxt = 4'd0;
                end
            end
            S_DRIVE: begin
                a_nxt   = {3'd0, a_bit_c} << g_q;
                b_nxt   = {3'd0, b_bit_c} << g_q;
                cnt_nxt = CNT_W'(SETTLE - 1);
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
            end
            S_CHECK: begin
                if (any_mism_c) begin
                    // err_q==0 marks the first failing check of this run
                    if (err_q == 4'd0) begin
                        fg_nxt = lowest_bit(mism_c);
                        fv_nxt = v_q;
                    end
                    if (err_q != 4'(ERR_MAX)) err_nxt = err_q + 4'd1;
                end
                {g_nxt, v_nxt} = {g_q, v_q} + 4'd1;
                if (state_nxt == S_DONE) begin
                    a_nxt = 4'd0;
                    b_nxt = 4'd0;
                end
            end
            default: ;
        endcase
        busy_nxt = (state_nxt == S_DRIVE) || (state_nxt == S_WAIT) || (state_nxt == S_CHECK);
        done_nxt = (state_nxt == S_DONE);
        pass_nxt = done_nxt && (err_nxt == 4'd0);
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_gate = fg_q;
    assign bus.fail_vec  = fv_q;
    assign bus.err_count = err_q;

endmodule
